// File: rtl/ex_se_pipe.sv
// EX-stage speculation check: finds the oldest mispredicted lane, squashes younger lanes and
// raises a one-cycle redirect to LS. Define NCPU_EX_SE_PERF_EN to add se_miss_cnt/se_miss_clr.
module ex_se_pipe #(
   parameter int CONFIG_P_ISSUE_WIDTH = 1,
   parameter int CONFIG_NUM_BRU       = 1,
   parameter int CONFIG_DW            = 64,
   parameter int CONFIG_PC_W          = 62,
   localparam int IW = 1 << CONFIG_P_ISSUE_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stall,
   input  logic                        flush,
`ifdef NCPU_EX_SE_PERF_EN
   input  logic                        se_miss_clr,
   output logic [31:0]                 se_miss_cnt,
`endif
   input  logic [IW-1:0]               ex_valid,
   input  logic [CONFIG_PC_W*IW-1:0]   ex_pc,
   input  logic [IW-1:0]               ex_b_taken,
   input  logic [CONFIG_PC_W*IW-1:0]   ex_b_tgt,
   input  logic [IW-1:0]               ex_pred_taken,
   input  logic [CONFIG_PC_W*IW-1:0]   ex_pred_tgt,
   input  logic [CONFIG_DW*IW-1:0]     ex_rf_dout,
   input  logic [5*IW-1:0]             ex_rf_waddr,
   input  logic [IW-1:0]               ex_rf_we,
   output logic [IW-1:0]               ls_valid,
   output logic [CONFIG_DW*IW-1:0]     ls_rf_dout,
   output logic [5*IW-1:0]             ls_rf_waddr,
   output logic [IW-1:0]               ls_rf_we,
   output logic                        ls_se_flush,
   output logic [CONFIG_PC_W-1:0]      ls_se_flush_tgt
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_SHADOW = 1'b1
   } state_e;

   state_e                   state_q, state_d;
   logic [IW-1:0]            lane_fail;
   logic [IW-1:0]            lane_keep;
   logic [CONFIG_PC_W-1:0]   lane_tgt [IW];
   logic [CONFIG_PC_W-1:0]   win_tgt;
   logic                     fail_any;
   logic                     fail_accept;
   logic [IW-1:0]            valid_q, valid_d;
   logic                     se_flush_q, se_flush_d;
   logic [CONFIG_PC_W-1:0]   se_tgt_q;
   logic [CONFIG_DW*IW-1:0]  rf_dout_q;
   logic [5*IW-1:0]          rf_waddr_q;
   logic [IW-1:0]            rf_we_q;

   generate
      for (genvar gi = 0; gi < IW; gi++) begin : g_lane
         logic [CONFIG_PC_W-1:0] pc_seq;
         assign pc_seq = ex_pc[gi*CONFIG_PC_W +: CONFIG_PC_W] + CONFIG_PC_W'(1);

         if (gi < CONFIG_NUM_BRU) begin : g_bru
            logic                   b_tk, p_tk;
            logic [CONFIG_PC_W-1:0] b_tgt, p_tgt;
            assign b_tk  = ex_b_taken[gi];
            assign p_tk  = ex_pred_taken[gi];
            assign b_tgt = ex_b_tgt[gi*CONFIG_PC_W +: CONFIG_PC_W];
            assign p_tgt = ex_pred_tgt[gi*CONFIG_PC_W +: CONFIG_PC_W];
            assign lane_fail[gi] = ex_valid[gi] &
                                   ((b_tk ^ p_tk) | (b_tk & p_tk & (b_tgt != p_tgt)));
            assign lane_tgt[gi]  = b_tk ? b_tgt : pc_seq;
         end else begin : g_alu
            // Non-branch lanes can only be wrong by having been predicted taken.
            logic lane_unused;
            assign lane_unused = ^{ex_b_taken[gi],
                                   ex_b_tgt[gi*CONFIG_PC_W +: CONFIG_PC_W],
                                   ex_pred_tgt[gi*CONFIG_PC_W +: CONFIG_PC_W]};
            assign lane_fail[gi] = ex_valid[gi] & ex_pred_taken[gi];
            assign lane_tgt[gi]  = pc_seq;
         end

         if (gi == 0) begin : g_first
            assign lane_keep[gi] = 1'b1;
         end else begin : g_rest
            assign lane_keep[gi] = ~|lane_fail[gi-1:0];
         end
      end
   endgenerate

   assign fail_any = |lane_fail;

   always_comb begin
      win_tgt = lane_tgt[IW-1];
      for (int i = IW - 2; i >= 0; i--) begin
         if (lane_fail[i]) win_tgt = lane_tgt[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      se_flush_d  = se_flush_q;
      fail_accept = 1'b0;
      if (flush) begin
         state_d    = ST_RUN;
         valid_d    = '0;
         se_flush_d = 1'b0;
      end else if (!stall) begin
         case (state_q)
            ST_RUN: begin
               valid_d     = ex_valid & lane_keep;
               se_flush_d  = fail_any;
               fail_accept = fail_any;
               if (fail_any) state_d = ST_SHADOW;
            end
            default: begin
               valid_d    = '0;
               se_flush_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         valid_q    <= '0;
         se_flush_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         se_flush_q <= se_flush_d;
      end
   end

   // Payload is only meaningful alongside its valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (!stall) begin
         se_tgt_q   <= win_tgt;
         rf_dout_q  <= ex_rf_dout;
         rf_waddr_q <= ex_rf_waddr;
         rf_we_q    <= ex_rf_we;
      end
   end

   assign ls_valid        = valid_q;
   assign ls_se_flush     = se_flush_q;
   assign ls_se_flush_tgt = se_tgt_q;
   assign ls_rf_dout      = rf_dout_q;
   assign ls_rf_waddr     = rf_waddr_q;
   assign ls_rf_we        = rf_we_q;

`ifdef NCPU_EX_SE_PERF_EN
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      miss_cnt_d = miss_cnt_q;
      if (se_miss_clr)      miss_cnt_d = '0;
      else if (fail_accept) miss_cnt_d = miss_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) miss_cnt_q <= '0;
      else     miss_cnt_q <= miss_cnt_d;
   end

   assign se_miss_cnt = miss_cnt_q;
`else
   logic perf_unused;
   assign perf_unused = fail_accept;
`endif

endmodule

// File: tb/tb_ex_se_pipe.sv
// Randomized + directed bench for ex_se_pipe (2 lanes, both branch-capable) against a
// lane-rule reference model.
module tb_ex_se_pipe;
   localparam int IW   = 2;
   localparam int NBRU = 2;
   localparam int DW   = 64;
   localparam int PCW  = 62;

   logic                 clk;
   logic                 rst = 1'b0;
   logic                 stall, flush, clr_v;
   logic [IW-1:0]        ex_valid, ex_b_taken, ex_pred_taken, ex_rf_we;
   logic [PCW*IW-1:0]    ex_pc, ex_b_tgt, ex_pred_tgt;
   logic [DW*IW-1:0]     ex_rf_dout;
   logic [5*IW-1:0]      ex_rf_waddr;
   logic [IW-1:0]        ls_valid, ls_rf_we;
   logic [DW*IW-1:0]     ls_rf_dout;
   logic [5*IW-1:0]      ls_rf_waddr;
   logic                 ls_se_flush;
   logic [PCW-1:0]       ls_se_flush_tgt;
`ifdef NCPU_EX_SE_PERF_EN
   logic                 se_miss_clr;
   logic [31:0]          se_miss_cnt;
   assign se_miss_clr = clr_v;
`endif

   ex_se_pipe #(
      .CONFIG_P_ISSUE_WIDTH(1),
      .CONFIG_NUM_BRU(NBRU),
      .CONFIG_DW(DW),
      .CONFIG_PC_W(PCW)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
`ifdef NCPU_EX_SE_PERF_EN
      .se_miss_clr(se_miss_clr), .se_miss_cnt(se_miss_cnt),
`endif
      .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_b_taken(ex_b_taken), .ex_b_tgt(ex_b_tgt),
      .ex_pred_taken(ex_pred_taken), .ex_pred_tgt(ex_pred_tgt),
      .ex_rf_dout(ex_rf_dout), .ex_rf_waddr(ex_rf_waddr), .ex_rf_we(ex_rf_we),
      .ls_valid(ls_valid), .ls_rf_dout(ls_rf_dout), .ls_rf_waddr(ls_rf_waddr),
      .ls_rf_we(ls_rf_we), .ls_se_flush(ls_se_flush), .ls_se_flush_tgt(ls_se_flush_tgt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_txn = 0;

   // Reference model state: what LS should show after the next edge.
   logic [IW-1:0]     m_valid;
   logic              m_fl, m_shadow;
   logic [PCW-1:0]    m_tgt;
   logic [31:0]       m_cnt;
   logic [DW*IW-1:0]  m_dout;
   logic [5*IW-1:0]   m_waddr;
   logic [IW-1:0]     m_we;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, n_txn);
      end
   endtask

   task automatic set_lane(input int i, input bit v, input logic [PCW-1:0] pc,
                           input bit bt, input logic [PCW-1:0] btgt,
                           input bit pt, input logic [PCW-1:0] ptgt);
      ex_valid[i]              = v;
      ex_pc[i*PCW +: PCW]      = pc;
      ex_b_taken[i]            = bt;
      ex_b_tgt[i*PCW +: PCW]   = btgt;
      ex_pred_taken[i]         = pt;
      ex_pred_tgt[i*PCW +: PCW] = ptgt;
   endtask

   task automatic idle_inputs();
      stall = 1'b0; flush = 1'b0; clr_v = 1'b0;
      for (int i = 0; i < IW; i++) begin
         set_lane(i, 1'b0, PCW'({$urandom(), $urandom()}), 1'b0, PCW'($urandom()),
                  1'b0, PCW'($urandom()));
         ex_rf_dout[i*DW +: DW] = {$urandom(), $urandom()};
         ex_rf_waddr[i*5 +: 5]  = 5'($urandom());
         ex_rf_we[i]            = 1'($urandom());
      end
   endtask

   function automatic bit lane_fails(input int i);
      bit bt, pt;
      bt = ex_b_taken[i];
      pt = ex_pred_taken[i];
      if (!ex_valid[i]) return 1'b0;
      if (i < NBRU)
         return (bt != pt) || (bt && pt && (ex_b_tgt[i*PCW +: PCW] != ex_pred_tgt[i*PCW +: PCW]));
      return pt;
   endfunction

   function automatic logic [PCW-1:0] redirect(input int i);
      logic [PCW-1:0] r;
      if (i < NBRU && ex_b_taken[i]) r = ex_b_tgt[i*PCW +: PCW];
      else                           r = ex_pc[i*PCW +: PCW] + 1;
      return r;
   endfunction

   task automatic model_next();
      int k;
      if (!stall) begin
         m_dout = ex_rf_dout; m_waddr = ex_rf_waddr; m_we = ex_rf_we;
      end
      if (flush) begin
         m_valid = '0; m_fl = 1'b0; m_shadow = 1'b0;
      end else if (!stall) begin
         if (m_shadow) begin
            m_valid = '0; m_fl = 1'b0;
         end else begin
            k = -1;
            for (int i = 0; i < IW; i++) if (k < 0 && lane_fails(i)) k = i;
            if (k < 0) begin
               m_valid = ex_valid; m_fl = 1'b0;
            end else begin
               m_valid  = ex_valid & IW'((1 << (k + 1)) - 1);
               m_fl     = 1'b1;
               m_tgt    = redirect(k);
               m_shadow = 1'b1;
               m_cnt    = m_cnt + 32'd1;
            end
         end
      end
      if (clr_v) m_cnt = '0;
   endtask

   task automatic check_outputs();
      chk("ls_valid", 64'(ls_valid), 64'(m_valid));
      chk("ls_se_flush", 64'(ls_se_flush), 64'(m_fl));
      if (m_fl) chk("ls_se_flush_tgt", 64'(ls_se_flush_tgt), 64'(m_tgt));
      for (int i = 0; i < IW; i++) begin
         if (m_valid[i]) begin
            chk("ls_rf_dout", ls_rf_dout[i*DW +: DW], m_dout[i*DW +: DW]);
            chk("ls_rf_waddr", 64'(ls_rf_waddr[i*5 +: 5]), 64'(m_waddr[i*5 +: 5]));
            chk("ls_rf_we", 64'(ls_rf_we[i]), 64'(m_we[i]));
         end
      end
`ifdef NCPU_EX_SE_PERF_EN
      chk("se_miss_cnt", 64'(se_miss_cnt), 64'(m_cnt));
`endif
   endtask

   task automatic step();
      model_next();
      @(posedge clk);
      #1;
      check_outputs();
      $display("txn %0d stall=%0b flush=%0b ex_valid=%b -> ls_valid=%b se_flush=%0b tgt=%0h",
               n_txn, stall, flush, ex_valid, ls_valid, ls_se_flush, ls_se_flush_tgt);
      n_txn++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_ls_valid", 64'(ls_valid), 64'd0);
      chk("rst_se_flush", 64'(ls_se_flush), 64'd0);
`ifdef NCPU_EX_SE_PERF_EN
      chk("rst_cnt", 64'(se_miss_cnt), 64'd0);
`endif
      m_valid = '0; m_fl = 1'b0; m_shadow = 1'b0; m_cnt = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("txn %0d reset", n_txn);
      n_txn++;
   endtask

   // Lane0: predicted not-taken, resolved taken to tgt; lane1 valid and correct.
   task automatic mispredict0(input logic [PCW-1:0] tgt);
      set_lane(0, 1'b1, PCW'('h100), 1'b1, tgt, 1'b0, PCW'(0));
      set_lane(1, 1'b1, PCW'('h101), 1'b0, PCW'(0), 1'b0, PCW'(0));
   endtask

   task automatic good_pair();
      set_lane(0, 1'b1, PCW'('h200), 1'b0, PCW'(0), 1'b0, PCW'(7));
      set_lane(1, 1'b1, PCW'('h201), 1'b1, PCW'('h30), 1'b1, PCW'('h30));
   endtask

   task automatic do_flush();
      idle_inputs(); flush = 1'b1; step(); flush = 1'b0;
   endtask

   initial begin
      logic [PCW-1:0] all1;
      all1 = '1;
      idle_inputs();
      #2;
      do_reset();
      idle_inputs(); step();

      // Oldest-lane mispredict
      idle_inputs(); mispredict0(PCW'('h40)); step();
      chk("r33_flush", 64'(ls_se_flush), 64'd1);
      chk("r33_tgt", 64'(ls_se_flush_tgt), 64'h40);
      chk("r33_valid", 64'(ls_valid), 64'b01);

      // Shadow squashes everything, no new redirect, until flush
      for (int c = 0; c < 3; c++) begin
         idle_inputs(); mispredict0(PCW'('h44)); step();
         chk("r34_valid", 64'(ls_valid), 64'd0);
         chk("r34_flush", 64'(ls_se_flush), 64'd0);
      end
      do_flush();
      idle_inputs(); good_pair(); step();
      chk("r34_pass", 64'(ls_valid), 64'b11);

      // PC wrap on lane1 not-taken redirect
      idle_inputs(); good_pair();
      set_lane(1, 1'b1, all1, 1'b0, PCW'(0), 1'b1, PCW'('h55)); step();
      chk("r35_tgt", 64'(ls_se_flush_tgt), 64'd0);
      chk("r35_valid", 64'(ls_valid), 64'b11);
      do_flush();

      // Target mismatch with both taken; not-taken ignores pred_tgt
      idle_inputs(); set_lane(0, 1'b1, PCW'(5), 1'b1, PCW'('h10), 1'b1, PCW'('h14)); step();
      chk("r36_flush", 64'(ls_se_flush), 64'd1);
      chk("r36_tgt", 64'(ls_se_flush_tgt), 64'h10);
      do_flush();
      idle_inputs(); set_lane(0, 1'b1, PCW'(5), 1'b0, PCW'('h10), 1'b0, PCW'('h14)); step();
      chk("r36_noflush", 64'(ls_se_flush), 64'd0);

      // Stall holds; exactly one pulse; pulse held under stall; flush beats fail
      idle_inputs(); good_pair(); step();
      for (int c = 0; c < 2; c++) begin
         idle_inputs(); mispredict0(PCW'('h80)); stall = 1'b1; step();
         chk("r37_hold_valid", 64'(ls_valid), 64'b11);
         chk("r37_hold_flush", 64'(ls_se_flush), 64'd0);
      end
      idle_inputs(); mispredict0(PCW'('h80)); step();
      chk("r37_pulse", 64'(ls_se_flush), 64'd1);
      idle_inputs(); stall = 1'b1; step();
      chk("r37_pulse_held", 64'(ls_se_flush), 64'd1);
      idle_inputs(); mispredict0(PCW'('h84)); step();
      chk("r37_single", 64'(ls_se_flush), 64'd0);
      do_flush();
      idle_inputs(); mispredict0(PCW'('h88)); flush = 1'b1; step();
      chk("r37_flush_wins", 64'(ls_se_flush), 64'd0);
      idle_inputs(); mispredict0(PCW'('h8c)); step();
      chk("r37_run_after", 64'(ls_se_flush), 64'd1);
      do_flush();

      // Miss counter, clear priority, reset mid-shadow
      do_reset();
      for (int c = 0; c < 3; c++) begin
         idle_inputs(); mispredict0(PCW'(c)); step(); do_flush();
      end
`ifdef NCPU_EX_SE_PERF_EN
      chk("r38_cnt3", 64'(se_miss_cnt), 64'd3);
`endif
      idle_inputs(); mispredict0(PCW'('h90)); clr_v = 1'b1; step();
`ifdef NCPU_EX_SE_PERF_EN
      chk("r38_clr", 64'(se_miss_cnt), 64'd0);
`endif
      idle_inputs();
      do_reset();
      idle_inputs(); mispredict0(PCW'('h94)); step();
      chk("r38_run_after_rst", 64'(ls_se_flush), 64'd1);

      // Randomized traffic
      for (int c = 0; c < 500; c++) begin
         idle_inputs();
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 5) == 0);
         clr_v = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < IW; i++)
            set_lane(i, 1'($urandom()),
                     ($urandom_range(0, 7) == 0) ? all1 : PCW'({$urandom(), $urandom()}),
                     1'($urandom()), PCW'($urandom_range(0, 3)),
                     1'($urandom()), PCW'($urandom_range(0, 3)));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
